// File: rtl/decode_stage_if.sv
// Decode stage bundle: fetch latch and writeback in, EXE latch and stalls out.
// master = upstream/downstream environment, slave = decode_stage.
interface decode_stage_if;
   logic        DE_V;
   logic [63:0] DE_PC;
   logic [63:0] DE_NPC;
   logic [31:0] DE_IR;
   logic        WB_V;
   logic [4:0]  WB_RD;
   logic [63:0] WB_DATA;
   logic        V_DEP_STALL;
   logic        V_DE_FE_BR_STALL;
   logic        EXE_V;
   logic [63:0] EXE_PC;
   logic [63:0] EXE_NPC;
   logic [31:0] EXE_IR;
   logic [63:0] EXE_RS1_VAL;
   logic [63:0] EXE_RS2_VAL;
   logic [63:0] EXE_IMM;
   logic [4:0]  EXE_RD;
   logic        EXE_WE;
   logic        EXE_ILLEGAL;

   modport master (
      output DE_V, DE_PC, DE_NPC, DE_IR,
      output WB_V, WB_RD, WB_DATA,
      input  V_DEP_STALL, V_DE_FE_BR_STALL,
      input  EXE_V, EXE_PC, EXE_NPC, EXE_IR,
      input  EXE_RS1_VAL, EXE_RS2_VAL, EXE_IMM,
      input  EXE_RD, EXE_WE, EXE_ILLEGAL
   );

   modport slave (
      input  DE_V, DE_PC, DE_NPC, DE_IR,
      input  WB_V, WB_RD, WB_DATA,
      output V_DEP_STALL, V_DE_FE_BR_STALL,
      output EXE_V, EXE_PC, EXE_NPC, EXE_IR,
      output EXE_RS1_VAL, EXE_RS2_VAL, EXE_IMM,
      output EXE_RD, EXE_WE, EXE_ILLEGAL
   );
endinterface

// File: rtl/decode_stage.sv
// RV64I decode: regfile read w/ WB bypass, immediates, scoreboard, EXE latch.
// Optional: `define DECODE_ILLEGAL_CHECK_EN flags unknown opcodes as illegal.
module decode_stage #(
   parameter int SB_CNT_W = 2,
   parameter bit RF_RESET = 1'b1
) (
   input logic           CLK,
   input logic           RESET,
   decode_stage_if.slave bus
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
   localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

   logic [31:0] ir;
   logic [6:0]  opc;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [63:0] imm_i;
   logic [63:0] imm_s;
   logic [63:0] imm_b;
   logic [63:0] imm_u;
   logic [63:0] imm_j;

   assign ir  = bus.DE_IR;
   assign opc = ir[6:0];
   assign rd  = ir[11:7];
   assign rs1 = ir[19:15];
   assign rs2 = ir[24:20];

   assign imm_i = {{52{ir[31]}}, ir[31:20]};
   assign imm_s = {{52{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{51{ir[31]}}, ir[31], ir[7],
                   ir[30:25], ir[11:8], 1'b0};
   assign imm_u = {{32{ir[31]}}, ir[31:12], 12'b0};
   assign imm_j = {{43{ir[31]}}, ir[31], ir[19:12],
                   ir[20], ir[30:21], 1'b0};

   logic        use_rs1;
   logic        use_rs2;
   logic        use_rd;
   logic        illegal;
   logic        we_next;
   logic [63:0] imm;

`ifdef DECODE_ILLEGAL_CHECK_EN
   function automatic logic is_known(input logic [6:0] o);
      case (o)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
         OP_LOAD, OP_IMM, OP_IMM32, OP_OP,
         OP_OP32, OP_BRANCH, OP_STORE,
         OP_FENCE, OP_SYSTEM: is_known = 1'b1;
         default:             is_known = 1'b0;
      endcase
   endfunction
`endif

   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      imm     = '0;
      case (opc)
         OP_LUI, OP_AUIPC: begin
            use_rd = 1'b1;
            imm    = imm_u;
         end
         OP_JAL: begin
            use_rd = 1'b1;
            imm    = imm_j;
         end
         OP_JALR, OP_LOAD, OP_IMM, OP_IMM32: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            imm     = imm_i;
         end
         OP_OP, OP_OP32: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         OP_BRANCH: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm     = imm_b;
         end
         OP_STORE: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm     = imm_s;
         end
         OP_FENCE, OP_SYSTEM: imm = imm_i;
         default: ;
      endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
      illegal = !is_known(opc) || (ir[1:0] != 2'b11);
      if (illegal) begin
         use_rs1 = 1'b0;
         use_rs2 = 1'b0;
         use_rd  = 1'b0;
      end
`else
      illegal = 1'b0;
`endif
      we_next = use_rd && (rd != 5'd0);
   end

   // Register file; x0 is never written and reads are forced to zero.
   logic [63:0] rf [32];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         if (RF_RESET) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
         end
      end else if (bus.WB_V && bus.WB_RD != 5'd0) begin
         rf[bus.WB_RD] <= bus.WB_DATA;
      end
   end

   logic [63:0] rs1_val;
   logic [63:0] rs2_val;

   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1 != 5'd0) begin
         if (bus.WB_V && bus.WB_RD == rs1) rs1_val = bus.WB_DATA;
         else                              rs1_val = rf[rs1];
      end
      if (rs2 != 5'd0) begin
         if (bus.WB_V && bus.WB_RD == rs2) rs2_val = bus.WB_DATA;
         else                              rs2_val = rf[rs2];
      end
   end

   logic [SB_CNT_W-1:0] cnt [32];
   logic                rs1_wait;
   logic                rs2_wait;
   logic                rd_full;
   logic                dep_stall;
   logic                br_stall;
   logic                issue;

   // A source is released early when this cycle's WB retires its last writer.
   always_comb begin
      rs1_wait = use_rs1 && rs1 != 5'd0 && cnt[rs1] != '0 &&
                 !(bus.WB_V && bus.WB_RD == rs1 && cnt[rs1] == CNT_ONE);
      rs2_wait = use_rs2 && rs2 != 5'd0 && cnt[rs2] != '0 &&
                 !(bus.WB_V && bus.WB_RD == rs2 && cnt[rs2] == CNT_ONE);
      rd_full  = we_next && cnt[rd] == CNT_MAX;
      dep_stall = bus.DE_V && (rs1_wait || rs2_wait || rd_full);
      br_stall  = bus.DE_V &&
                  (opc == OP_BRANCH || opc == OP_JAL || opc == OP_JALR);
      issue     = bus.DE_V && !dep_stall && we_next;
   end

   assign bus.V_DEP_STALL      = dep_stall;
   assign bus.V_DE_FE_BR_STALL = br_stall;

   logic [31:0] inc_vec;
   logic [31:0] dec_vec;

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (issue)    inc_vec[rd]         = 1'b1;
      if (bus.WB_V) dec_vec[bus.WB_RD]  = 1'b1;
   end

   always_ff @(posedge CLK) begin
      cnt[0] <= '0;
      if (RESET) begin
         for (int r = 1; r < 32; r++) cnt[r] <= '0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            if (inc_vec[r] && !dec_vec[r])
               cnt[r] <= cnt[r] + CNT_ONE;
            else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
               cnt[r] <= cnt[r] - CNT_ONE;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         bus.EXE_V       <= 1'b0;
         bus.EXE_PC      <= '0;
         bus.EXE_NPC     <= '0;
         bus.EXE_IR      <= '0;
         bus.EXE_RS1_VAL <= '0;
         bus.EXE_RS2_VAL <= '0;
         bus.EXE_IMM     <= '0;
         bus.EXE_RD      <= '0;
         bus.EXE_WE      <= 1'b0;
         bus.EXE_ILLEGAL <= 1'b0;
      end else if (dep_stall) begin
         bus.EXE_V <= 1'b0;
      end else begin
         bus.EXE_V       <= bus.DE_V;
         bus.EXE_PC      <= bus.DE_PC;
         bus.EXE_NPC     <= bus.DE_NPC;
         bus.EXE_IR      <= ir;
         bus.EXE_RS1_VAL <= rs1_val;
         bus.EXE_RS2_VAL <= rs2_val;
         bus.EXE_IMM     <= imm;
         bus.EXE_RD      <= rd;
         bus.EXE_WE      <= we_next;
         bus.EXE_ILLEGAL <= illegal;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage.
// Inputs change 1ns after posedge; registered outputs sampled there too.
module tb_decode_stage;

   logic CLK = 1'b0;
   logic RESET;
   int   n_chk = 0;
   int   n_fail = 0;

   decode_stage_if bus ();

   decode_stage #(.SB_CNT_W(2), .RF_RESET(1'b1)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

`ifdef DECODE_ILLEGAL_CHECK_EN
   localparam logic EXP_ILL = 1'b1;
`else
   localparam logic EXP_ILL = 1'b0;
`endif

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.DE_V    = 1'b0;
      bus.DE_PC   = '0;
      bus.DE_NPC  = '0;
      bus.DE_IR   = '0;
      bus.WB_V    = 1'b0;
      bus.WB_RD   = '0;
      bus.WB_DATA = '0;
   endtask

   task automatic test_reset();
      idle();
      RESET = 1'b1;
      cyc();
      cyc();
      n_chk++;
      if (bus.EXE_V !== 1'b0 || bus.EXE_RD !== 5'd0 ||
          bus.EXE_IMM !== 64'd0 || bus.EXE_WE !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_exe: v=%b rd=%0d imm=%0h we=%b expected all 0",
                  bus.EXE_V, bus.EXE_RD, bus.EXE_IMM, bus.EXE_WE);
      end
      n_chk++;
      if (bus.V_DEP_STALL !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stall: got %b expected 0", bus.V_DEP_STALL);
      end
      RESET = 1'b0;
   endtask

   task automatic test_addi();
      bus.DE_V   = 1'b1;
      bus.DE_IR  = 32'h00500093;
      bus.DE_PC  = 64'h1000;
      bus.DE_NPC = 64'h1004;
      #1;
      n_chk++;
      if (bus.V_DEP_STALL !== 1'b0 || bus.V_DE_FE_BR_STALL !== 1'b0) begin
         n_fail++;
         $display("FAIL addi_stall: dep=%b br=%b expected 0 0",
                  bus.V_DEP_STALL, bus.V_DE_FE_BR_STALL);
      end
      cyc();
      bus.DE_V = 1'b0;
      n_chk++;
      if (bus.EXE_V !== 1'b1 || bus.EXE_RD !== 5'd1 || bus.EXE_WE !== 1'b1) begin
         n_fail++;
         $display("FAIL addi_ctl: v=%b rd=%0d we=%b expected 1 1 1",
                  bus.EXE_V, bus.EXE_RD, bus.EXE_WE);
      end
      n_chk++;
      if (bus.EXE_IMM !== 64'd5 || bus.EXE_RS1_VAL !== 64'd0) begin
         n_fail++;
         $display("FAIL addi_data: imm=%0h rs1=%0h expected 5 0",
                  bus.EXE_IMM, bus.EXE_RS1_VAL);
      end
      n_chk++;
      if (bus.EXE_PC !== 64'h1000 || bus.EXE_NPC !== 64'h1004 ||
          bus.EXE_IR !== 32'h00500093) begin
         n_fail++;
         $display("FAIL addi_copy: pc=%0h npc=%0h ir=%0h expected 1000 1004 500093",
                  bus.EXE_PC, bus.EXE_NPC, bus.EXE_IR);
      end
   endtask

   task automatic test_dep_stall();
      bus.DE_V  = 1'b1;
      bus.DE_IR = 32'h00108133;
      #1;
      n_chk++;
      if (bus.V_DEP_STALL !== 1'b1) begin
         n_fail++;
         $display("FAIL dep_stall_on: got %b expected 1", bus.V_DEP_STALL);
      end
      cyc();
      n_chk++;
      if (bus.EXE_V !== 1'b0 || bus.EXE_RD !== 5'd1) begin
         n_fail++;
         $display("FAIL dep_bubble: v=%b rd=%0d expected 0 1(held)",
                  bus.EXE_V, bus.EXE_RD);
      end
      n_chk++;
      if (bus.V_DEP_STALL !== 1'b1) begin
         n_fail++;
         $display("FAIL dep_stall_hold: got %b expected 1", bus.V_DEP_STALL);
      end
      bus.WB_V    = 1'b1;
      bus.WB_RD   = 5'd1;
      bus.WB_DATA = 64'h5;
      #1;
      n_chk++;
      if (bus.V_DEP_STALL !== 1'b0) begin
         n_fail++;
         $display("FAIL dep_release: got %b expected 0", bus.V_DEP_STALL);
      end
      cyc();
      n_chk++;
      if (bus.EXE_V !== 1'b1 || bus.EXE_RD !== 5'd2 ||
          bus.EXE_RS1_VAL !== 64'd5 || bus.EXE_RS2_VAL !== 64'd5) begin
         n_fail++;
         $display("FAIL dep_bypass: v=%b rd=%0d rs1=%0h rs2=%0h expected 1 2 5 5",
                  bus.EXE_V, bus.EXE_RD, bus.EXE_RS1_VAL, bus.EXE_RS2_VAL);
      end
      bus.DE_V    = 1'b0;
      bus.WB_RD   = 5'd2;
      bus.WB_DATA = 64'hA;
      cyc();
      bus.WB_V = 1'b0;
   endtask

   task automatic test_sb_overflow();
      bus.DE_V  = 1'b1;
      bus.DE_IR = 32'h00100193;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("ovf_issue%0d_stall", k), 64'(bus.V_DEP_STALL), 64'd0);
         cyc();
         chk($sformatf("ovf_issue%0d_v", k), 64'(bus.EXE_V), 64'd1);
      end
      chk("ovf_full_stall", 64'(bus.V_DEP_STALL), 64'd1);
      cyc();
      chk("ovf_full_bubble", 64'(bus.EXE_V), 64'd0);
      bus.WB_V    = 1'b1;
      bus.WB_RD   = 5'd3;
      bus.WB_DATA = 64'h7;
      #1;
      chk("ovf_wb_stall", 64'(bus.V_DEP_STALL), 64'd1);
      cyc();
      chk("ovf_wb_bubble", 64'(bus.EXE_V), 64'd0);
      bus.WB_V = 1'b0;
      #1;
      chk("ovf_release", 64'(bus.V_DEP_STALL), 64'd0);
      cyc();
      chk("ovf_fourth_v", 64'(bus.EXE_V), 64'd1);
      chk("ovf_fourth_rd", 64'(bus.EXE_RD), 64'd3);
      bus.DE_V = 1'b0;
      bus.WB_V = 1'b1;
      for (int k = 0; k < 3; k++) cyc();
      bus.WB_V = 1'b0;
   endtask

   task automatic test_branch();
      bus.DE_V   = 1'b1;
      bus.DE_IR  = 32'hFE000CE3;
      bus.DE_PC  = 64'h2000;
      bus.DE_NPC = 64'h2004;
      #1;
      chk("br_stall", 64'(bus.V_DE_FE_BR_STALL), 64'd1);
      chk("br_dep", 64'(bus.V_DEP_STALL), 64'd0);
      cyc();
      bus.DE_V = 1'b0;
      chk("br_imm", bus.EXE_IMM, 64'hFFFFFFFFFFFFFFF8);
      chk("br_we", 64'(bus.EXE_WE), 64'd0);
      #1;
      chk("br_stall_off", 64'(bus.V_DE_FE_BR_STALL), 64'd0);
   endtask

   task automatic test_wb_x0();
      bus.WB_V    = 1'b1;
      bus.WB_RD   = 5'd0;
      bus.WB_DATA = 64'hDEAD;
      bus.DE_V    = 1'b1;
      bus.DE_IR   = 32'h00000233;
      #1;
      chk("x0_stall", 64'(bus.V_DEP_STALL), 64'd0);
      cyc();
      chk("x0_rs1", bus.EXE_RS1_VAL, 64'd0);
      chk("x0_rs2", bus.EXE_RS2_VAL, 64'd0);
      bus.WB_V  = 1'b0;
      bus.DE_IR = 32'h000082B3;
      cyc();
      chk("x1_read", bus.EXE_RS1_VAL, 64'd5);
      chk("x1_rd", 64'(bus.EXE_RD), 64'd5);
      bus.DE_V = 1'b0;
   endtask

   task automatic test_illegal();
      bus.DE_V  = 1'b1;
      bus.DE_IR = 32'h0000007F;
      #1;
      chk("ill_stall", 64'(bus.V_DEP_STALL), 64'd0);
      chk("ill_br", 64'(bus.V_DE_FE_BR_STALL), 64'd0);
      cyc();
      bus.DE_V = 1'b0;
      chk("ill_v", 64'(bus.EXE_V), 64'd1);
      chk("ill_flag", 64'(bus.EXE_ILLEGAL), 64'(EXP_ILL));
      chk("ill_we", 64'(bus.EXE_WE), 64'd0);
   endtask

   task automatic test_reset_midop();
      bus.DE_V  = 1'b1;
      bus.DE_IR = 32'h00000313;
      cyc();
      bus.DE_V    = 1'b0;
      RESET       = 1'b1;
      bus.WB_V    = 1'b1;
      bus.WB_RD   = 5'd7;
      bus.WB_DATA = 64'h99;
      cyc();
      chk("rst_mid_v", 64'(bus.EXE_V), 64'd0);
      RESET    = 1'b0;
      bus.WB_V = 1'b0;
      bus.DE_V  = 1'b1;
      bus.DE_IR = 32'h00730433;
      #1;
      chk("rst_mid_stall", 64'(bus.V_DEP_STALL), 64'd0);
      cyc();
      bus.DE_V = 1'b0;
      chk("rst_mid_rs1", bus.EXE_RS1_VAL, 64'd0);
      chk("rst_mid_rs2", bus.EXE_RS2_VAL, 64'd0);
   endtask

   initial begin
      RESET = 1'b1;
      test_reset();
      test_addi();
      test_dep_stall();
      test_sb_overflow();
      test_branch();
      test_wb_x0();
      test_illegal();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
